instr_fetch: RTL
================

# instr_fetch

- Sequential instruction-fetch and PC-sequencing unit for the unpipelined MIPS core.
- Role:
  - Issues word fetches to instruction memory over a req/ack handshake.
  - Presents each fetched instruction, and its opcode, to the control decoder and datapath.
  - On retirement, consumes the decoder's jump/beq/bne lines and the ALU zero flag to pick the next PC.
- This is the producer and consumer end of the opcode/control-line interface: it feeds the opcode in and acts on the flow-control outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored (treated as 0).

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_imemReq  out  1  fetch request to instruction memory.
- o_imemAddr  out  32  word-aligned fetch address; bits [1:0] always 0.
- i_imemAck  in  1  memory acknowledge; sampled only while o_imemReq=1.
- i_imemData  in  32  instruction word; valid in the ack cycle.
- o_instr  out  32  held instruction.
- o_opcode  out  6  o_instr[31:26], feeds the control decoder.
- o_instrValid  out  1  o_instr, o_opcode and o_pc are valid.
- i_instrReady  in  1  datapath retires the held instruction this cycle.
- i_jump, i_beq, i_bne  in  1 each  control-decoder outputs for the held instruction.
- i_zero  in  1  ALU zero flag for the held instruction.
- o_pc  out  32  address of the held instruction.
- o_pcPlus4  out  32  o_pc + 4, mod 2^32; combinational from o_pc.
- o_retireCount  out  32  number of retired instructions; wraps.

## Operation
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: entered on reset. Goes unconditionally to FETCH on the next edge.
  - FETCH: o_imemReq=1 and o_imemAddr=PC, both held stable until ack.
    - On an edge with i_imemAck=1: latch i_imemData into o_instr, go to HOLD.
  - HOLD: o_instrValid=1.
    - On an edge with i_instrReady=1: load next PC, increment o_retireCount, go to FETCH.
    - Otherwise stay in HOLD with all outputs stable.
- Next-PC selection at retirement, strict priority:
  - i_jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - else i_beq=1 and i_zero=1: pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else i_bne=1 and i_zero=0: the same branch target.
  - else: pc4.
  - Here pc4 = o_pcPlus4 and instr = o_instr.
- Arithmetic is 32-bit and wraps mod 2^32. PC 32'hFFFF_FFFC plus 4 gives 32'h0000_0000.
- Control inputs and i_zero are don't-care outside the HOLD retirement edge. X or Z values on them must not corrupt state unless i_instrReady=1 in HOLD.
- i_imemAck is ignored in IDLE and HOLD.
- i_instrReady is ignored in IDLE and FETCH.
- o_instr and o_pc hold their last values while in FETCH. o_instrValid gates their use.

## Timing
- Reset (asynchronous, immediate on i_rst assertion):
  - state=IDLE, PC=RESET_PC.
  - o_imemReq=0, o_instrValid=0, o_instr=0, o_retireCount=0.
  - o_opcode=0, o_pc=RESET_PC, o_pcPlus4=RESET_PC+4.
- First fetch: o_imemReq rises on the first edge after i_rst deasserts.
- Memory latency: zero-wait ack (ack in the first req cycle) gives o_instrValid=1 on the next cycle.
- Issue rate: with zero-wait memory and ready always high, one instruction retires every 2 cycles. Minimum spacing between retirements is 2 cycles.
- o_imemReq and o_instrValid are registered and never high in the same cycle.
- Reset mid-fetch or mid-hold:
  - Outstanding request abandoned.
  - A late ack after reset release, while in IDLE, is ignored.
  - Fetch restarts at RESET_PC.
- o_retireCount: 32'hFFFF_FFFF wraps to 0 on the next retirement.

## Test plan
- Reset, then zero-wait memory with ready=1 and no control lines: o_imemAddr sequence 0x0, 0x4, 0x8; o_retireCount=3 after the third retire; o_instrValid high every second cycle.
- Held instr 0x1000_0003 at pc 0x10 with i_beq=1:
  - i_zero=1 → next o_imemAddr = 0x20.
  - i_zero=0 → next o_imemAddr = 0x14.
  - Repeat with i_bne=1 and the opposite zero results.
- Held instr 0x0800_0040 at pc 0x4000_0000, i_jump=1 and i_beq=1 with i_zero=1 → next o_imemAddr = 0x4000_0100 (jump wins).
- Backward branch: instr imm16=16'hFFFF at pc 0x8 with beq taken → next o_imemAddr = 0x8. Separately, RESET_PC=0xFFFF_FFFC sequential fetch → next addr 0x0.
- Backpressure and memory wait states:
  - Ack delayed 3 cycles → req and addr stable across all 3.
  - Ready low 4 cycles in HOLD → outputs stable and no count change.
  - Spurious ack in HOLD → ignored.
- Assert i_rst during FETCH, then ack one cycle after release → ignored; outputs at reset values; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory handshake, decoder feed and retirement
// control lines. The master side is the fetch unit; the slave side is the
// memory/decoder/datapath environment.
interface instr_fetch_if;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;
  logic [31:0] o_instr;
  logic [5:0]  o_opcode;
  logic        o_instrValid;
  logic        i_instrReady;
  logic        i_jump;
  logic        i_beq;
  logic        i_bne;
  logic        i_zero;
  logic [31:0] o_pc;
  logic [31:0] o_pcPlus4;
  logic [31:0] o_retireCount;

  modport master (
    output o_imemReq, o_imemAddr, o_instr, o_opcode, o_instrValid,
           o_pc, o_pcPlus4, o_retireCount,
    input  i_imemAck, i_imemData, i_instrReady, i_jump, i_beq, i_bne, i_zero
  );

  modport slave (
    input  o_imemReq, o_imemAddr, o_instr, o_opcode, o_instrValid,
           o_pc, o_pcPlus4, o_retireCount,
    output i_imemAck, i_imemData, i_instrReady, i_jump, i_beq, i_bne, i_zero
  );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction fetch and PC sequencing for the unpipelined MIPS
// core. Fetches one word at a time over a req/ack handshake, holds it for the
// decoder/datapath, and picks the next PC from jump/beq/bne/zero on retire.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_fetch_if.master bus
);

  // Low address bits of the reset vector are forced to a word boundary.
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        fetch_done;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_nxt;
  logic [31:0] instr;
  logic [31:0] retire_count;

  // Region-relative jump: top nibble of pc+4 with the 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] word);
    return {pc_plus4[31:28], word[25:0], 2'b00};
  endfunction

  // PC-relative branch: sign-extended word offset added to pc+4, wrapping.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] word);
    return pc_plus4 + {{14{word[15]}}, word[15:0], 2'b00};
  endfunction

  assign pc4 = pc + 32'd4;

  // State register; reset abandons any outstanding request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ack and ready only matter in their own states.
  always_comb begin
    state_nxt  = state;
    fetch_done = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.i_imemAck == 1'b1) begin
          fetch_done = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_instrReady == 1'b1) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next-PC select with jump over beq over bne over sequential.
  always_comb begin
    pc_nxt = pc4;
    if (bus.i_jump == 1'b1) begin
      pc_nxt = jump_target(pc4, instr);
    end else if (bus.i_beq == 1'b1 && bus.i_zero == 1'b1) begin
      pc_nxt = branch_target(pc4, instr);
    end else if (bus.i_bne == 1'b1 && bus.i_zero == 1'b0) begin
      pc_nxt = branch_target(pc4, instr);
    end
  end

  // PC, held instruction and retire counter; only the qualified fetch and
  // retire strobes update them, so don't-care controls never leak in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc           <= RESET_PC_AL;
      instr        <= 32'd0;
      retire_count <= 32'd0;
    end else begin
      if (fetch_done) begin
        instr <= bus.i_imemData;
      end
      if (retire) begin
        pc           <= pc_nxt;
        retire_count <= retire_count + 32'd1;
      end
    end
  end

  assign bus.o_imemReq     = (state == FETCH);
  assign bus.o_instrValid  = (state == HOLD);
  assign bus.o_imemAddr    = pc;
  assign bus.o_instr       = instr;
  assign bus.o_opcode      = instr[31:26];
  assign bus.o_pc          = pc;
  assign bus.o_pcPlus4     = pc4;
  assign bus.o_retireCount = retire_count;

endmodule
